// File: rtl/main_ram_pkg.sv
// main_ram_pkg: shared defaults and derived widths for the slow main memory.
package main_ram_pkg;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DEPTH   = 1024;
    localparam int DEF_LATENCY = 4;
    localparam int IDX_W       = $clog2(DEF_DEPTH);

    function automatic int cnt_w(input int latency);
        return $clog2(latency) + 1;
    endfunction
endpackage

// File: rtl/main_ram_array.sv
// main_ram_array: single-port word storage with a registered read port.
module main_ram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    // Zero at configuration; deliberately untouched by reset.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        rdata <= mem[idx];
    end
endmodule

// File: rtl/main_ram.sv
// main_ram: latency-modelled main memory; a request is any change of data/addr/wr.
module main_ram
    import main_ram_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    output logic              response,
    output logic [DATA_W-1:0] out
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = cnt_w(LATENCY);

    logic [DATA_W-1:0] req_data, rdata;
    logic [ADDR_W-1:0] req_addr;
    logic              req_wr, busy, changed, done;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;

    // The array is read at the new address on the accepting edge, then keeps
    // re-reading the latched address, so rdata is valid by completion even for LATENCY=1.
    always_comb begin
        changed = (data != req_data) || (addr != req_addr) || (wr != req_wr);
        done    = busy && !changed && (cnt == '0);
        idx     = changed ? addr[IW-1:0] : req_addr[IW-1:0];
    end

    assign response = !busy && !changed;

    main_ram_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IW)) u_array (
        .clk   (clk),
        .we    (done && req_wr && !rst),
        .idx   (idx),
        .wdata (req_data),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            req_data <= '0;
            req_addr <= '0;
            req_wr   <= 1'b0;
            busy     <= 1'b0;
            cnt      <= '0;
            out      <= '0;
        end else if (changed) begin
            req_data <= data;
            req_addr <= addr;
            req_wr   <= wr;
            busy     <= 1'b1;
            cnt      <= CW'(LATENCY - 1);
        end else if (busy) begin
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else begin
                busy <= 1'b0;
                if (!req_wr) out <= rdata;
            end
        end
    end
endmodule

// File: tb/tb_main_ram.sv
// tb_main_ram: table vectors, corner sequences and randomized traffic against a memory model.
module tb_main_ram;
    localparam int LAT   = 4;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] data = '0, addr = '0, out;
    logic        wr = 1'b0, response;
    logic [31:0] d1 = '0, a1 = '0, out1;
    logic        w1 = 1'b0, resp1;

    int checks = 0, failures = 0;

    logic [31:0] mem_m [int];
    logic [31:0] out_m = '0, ld = '0, la = '0;
    logic        lw = 1'b0;

    typedef struct {
        logic [31:0] d;
        logic [31:0] a;
        logic        w;
        logic [31:0] exp_out;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    main_ram #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .data(data), .addr(addr), .wr(wr),
        .response(response), .out(out)
    );

    main_ram #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .data(d1), .addr(a1), .wr(w1),
        .response(resp1), .out(out1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int i;
        i = int'(a % DEPTH);
        return mem_m.exists(i) ? mem_m[i] : 32'h0;
    endfunction

    // Issue one request and check the response timing and resulting out against the model.
    task automatic do_req(input logic [31:0] d, input logic [31:0] a, input logic w);
        int  n;
        bit  same;
        same = (d == ld) && (a == la) && (w == lw);
        @(negedge clk);
        data = d; addr = a; wr = w;
        #1;
        chk("resp_on_change", {31'b0, response}, {31'b0, same});
        if (same) begin
            repeat (3) @(negedge clk);
            chk("resp_idle_same", {31'b0, response}, 32'd1);
            chk("out_idle_same", out, out_m);
        end else begin
            ld = d; la = a; lw = w;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!response && n < 20);
            chk("latency", n, LAT + 1);
            if (w) mem_m[int'(a % DEPTH)] = d;
            else out_m = mem_rd(a);
            chk("out_model", out, out_m);
        end
    endtask

    initial begin
        vecs[0] = '{32'hDEADBEEF, 32'd5,          1'b1, 32'h0};
        vecs[1] = '{32'hDEADBEEF, 32'd5,          1'b0, 32'hDEADBEEF};
        vecs[2] = '{32'h0,        32'd7,          1'b0, 32'h0};
        vecs[3] = '{32'h0,        DEPTH + 5,      1'b0, 32'hDEADBEEF};
        vecs[4] = '{32'h12345678, 32'd3,          1'b1, 32'hDEADBEEF};
        vecs[5] = '{32'h12345678, 32'd3,          1'b0, 32'h12345678};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_resp", {31'b0, response}, 32'd1);
            chk("idle_out", out, 32'h0);
        end
        chk("idle_resp1", {31'b0, resp1}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            do_req(vecs[i].d, vecs[i].a, vecs[i].w);
            chk($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
        end

        // Restart: write to 9 abandoned after two cycles in favour of a write to 10.
        @(negedge clk);
        data = 32'h11; addr = 32'd9; wr = 1'b1;
        ld = data; la = addr; lw = wr;
        repeat (2) begin
            @(negedge clk);
            chk("restart_busy", {31'b0, response}, 32'd0);
        end
        do_req(32'h11, 32'd10, 1'b1);
        do_req(32'h0, 32'd9, 1'b0);
        chk("abandoned_write", out, 32'h0);
        do_req(32'h0, 32'd10, 1'b0);
        chk("restarted_write", out, 32'h11);

        // Reset in the middle of a read.
        @(negedge clk);
        data = 32'h0; addr = 32'd5; wr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; addr = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_resp", {31'b0, response}, 32'd1);
        chk("rst_out", out, 32'h0);
        ld = '0; la = '0; lw = 1'b0; out_m = '0;
        do_req(32'h0, 32'd5, 1'b0);
        chk("after_rst_read", out, 32'hDEADBEEF);

        // LATENCY=1 instance: exactly one low sample after the accepting edge.
        @(negedge clk);
        d1 = 32'hCAFEF00D; a1 = 32'd2; w1 = 1'b1;
        #1 chk("l1_wr_change", {31'b0, resp1}, 32'd0);
        @(negedge clk) chk("l1_wr_busy", {31'b0, resp1}, 32'd0);
        @(negedge clk) chk("l1_wr_done", {31'b0, resp1}, 32'd1);
        chk("l1_wr_out", out1, 32'h0);
        w1 = 1'b0;
        #1 chk("l1_rd_change", {31'b0, resp1}, 32'd0);
        @(negedge clk) chk("l1_rd_busy", {31'b0, resp1}, 32'd0);
        @(negedge clk) chk("l1_rd_done", {31'b0, resp1}, 32'd1);
        chk("l1_rd_out", out1, 32'hCAFEF00D);

        // Randomized traffic, including aliased addresses and repeated identical requests.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] d, a;
            logic        w;
            if ($urandom_range(0, 5) == 0) begin
                d = ld; a = la; w = lw;
            end else begin
                d = $urandom;
                a = $urandom_range(0, 15) + (($urandom_range(0, 3) == 0) ? DEPTH * $urandom_range(1, 3) : 0);
                w = 1'($urandom_range(0, 1));
            end
            do_req(d, a, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
